// File: rtl/float_accum_12_if.sv
// rtl/float_accum_12_if.sv - beat/result handshake bundle for float_accum_12
//
// Purpose: groups the upstream beat stream and the downstream result stream.
// Ports (slave = accumulator view):
//   data_i[11:0], valid_i, last_i  upstream beat (product word, group end)
//   ready_o                        accumulator accepts a beat this cycle
//   data_o[11:0], ovf_o, count_o   finished group result
//   valid_o                        result holds valid data
//   ready_i                        downstream consumes the result this cycle
interface float_accum_12_if;
    logic [11:0] data_i;
    logic        valid_i;
    logic        last_i;
    logic        ready_o;
    logic [11:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        ovf_o;
    logic [7:0]  count_o;

    modport slave (
        input  data_i, valid_i, last_i, ready_i,
        output ready_o, data_o, valid_o, ovf_o, count_o
    );

    modport master (
        output data_i, valid_i, last_i, ready_i,
        input  ready_o, data_o, valid_o, ovf_o, count_o
    );
endinterface

// File: rtl/float_accum_12.sv
// rtl/float_accum_12.sv - 12-bit minifloat group accumulator with result handshake
//
// Purpose: sums groups of 12-bit floats ([11] sign, [10:6] exp bias 15,
// [5:0] fraction, hidden 1; exp 0 is zero), truncating, saturating on overflow.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset
//   bus    float_accum_12_if.slave (beat in, result out)
module float_accum_12 (
    input  logic              clk_i,
    input  logic              rst_i,
    float_accum_12_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [11:0] acc, acc_n;
    logic [7:0]  count, count_n;
    logic        ovf, ovf_n;
    logic [11:0] data_q, data_n;
    logic [7:0]  count_q, count_q_n;
    logic        ovf_q, ovf_q_n;

    logic        accept;
    logic        load_out;
    logic [11:0] beat_norm;
    logic [12:0] add_res;

    // Returns {overflow, sum}. Operand a is always a normalized word
    // (either 12'h000 or exponent >= 1).
    function automatic logic [12:0] fp_add(input logic [11:0] a, input logic [11:0] b);
        logic [4:0] ea, eb, e_big, e_sml, e_diff;
        logic [6:0] m_big, m_sml, m_al, dif, mant;
        logic [7:0] sum;
        logic [6:0] e_res;
        logic [2:0] lz;
        logic       a_big, s_big;
        ea     = a[10:6];
        eb     = b[10:6];
        // Magnitude order: exponent first, then fraction.
        a_big  = {ea, a[5:0]} >= {eb, b[5:0]};
        e_big  = a_big ? ea : eb;
        e_sml  = a_big ? eb : ea;
        m_big  = {1'b1, (a_big ? a[5:0] : b[5:0])};
        m_sml  = {1'b1, (a_big ? b[5:0] : a[5:0])};
        s_big  = a_big ? a[11] : b[11];
        e_diff = e_big - e_sml;
        m_al   = (e_diff >= 5'd8) ? 7'd0 : (m_sml >> e_diff);
        sum    = {1'b0, m_big} + {1'b0, m_al};
        dif    = m_big - m_al;
        // Leading-zero count of the difference; highest set bit wins.
        lz = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (dif[i]) lz = 3'(6 - i);
        end
        mant  = dif << lz;
        e_res = {2'b00, e_big} - {4'b0000, lz};

        fp_add = 13'd0;
        if (ea == 5'd0) begin
            fp_add = {1'b0, ((eb == 5'd0) ? 12'h000 : b)};
        end else if (eb == 5'd0) begin
            fp_add = {1'b0, a};
        end else if (a[11] == b[11]) begin
            if (sum[7]) begin
                if (e_big == 5'd31)
                    fp_add = {1'b1, s_big, 5'd31, 6'd63};
                else
                    fp_add = {1'b0, s_big, e_big + 5'd1, sum[6:1]};
            end else begin
                fp_add = {1'b0, s_big, e_big, sum[5:0]};
            end
        end else if (dif != 7'd0) begin
            // Underflow (exponent <= 0) flushes silently to zero.
            if (!e_res[6] && (e_res != 7'd0))
                fp_add = {1'b0, s_big, e_res[4:0], mant[5:0]};
        end
    endfunction

    assign beat_norm = (bus.data_i[10:6] == 5'd0) ? 12'h000 : bus.data_i;
    assign add_res   = fp_add(acc, bus.data_i);

    // A pending result blocks input unless it is being consumed this cycle.
    assign bus.ready_o = (state != DONE) || bus.ready_i;
    assign accept      = bus.valid_i && bus.ready_o;

    assign bus.valid_o = (state == DONE);
    assign bus.data_o  = data_q;
    assign bus.ovf_o   = ovf_q;
    assign bus.count_o = count_q;

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        count_n   = count;
        ovf_n     = ovf;
        data_n    = data_q;
        count_q_n = count_q;
        ovf_q_n   = ovf_q;
        load_out  = 1'b0;

        case (state)
            IDLE, DONE: begin
                if (state == DONE && bus.ready_i)
                    state_n = IDLE;
                if (accept) begin
                    // First beat of a group: replaces any stale sum.
                    acc_n   = beat_norm;
                    count_n = 8'd1;
                    ovf_n   = 1'b0;
                    state_n = bus.last_i ? DONE : ACC;
                    load_out = bus.last_i;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_n   = add_res[11:0];
                    count_n = (count == 8'd255) ? count : count + 8'd1;
                    ovf_n   = ovf | add_res[12];
                    if (bus.last_i) begin
                        state_n  = DONE;
                        load_out = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (load_out) begin
            data_n    = acc_n;
            count_q_n = count_n;
            ovf_q_n   = ovf_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            acc     <= 12'h000;
            count   <= 8'd0;
            ovf     <= 1'b0;
            data_q  <= 12'h000;
            count_q <= 8'd0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            count   <= count_n;
            ovf     <= ovf_n;
            data_q  <= data_n;
            count_q <= count_q_n;
            ovf_q   <= ovf_q_n;
        end
    end

endmodule

// File: tb/tb_float_accum_12.sv
// tb/tb_float_accum_12.sv - self-checking bench for float_accum_12
module tb_float_accum_12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    float_accum_12_if bus ();

    float_accum_12 dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: group in progress and pending result.
    logic        m_active = 1'b0;
    logic        m_pend   = 1'b0;
    logic [11:0] m_acc    = 12'h000;
    int          m_cnt    = 0;
    logic        m_ovf    = 1'b0;
    logic [11:0] m_out    = 12'h000;
    int          m_ocnt   = 0;
    logic        m_oovf   = 1'b0;
    logic [11:0] held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] norm(input logic [11:0] w);
        return (w[10:6] == 5'd0) ? 12'h000 : w;
    endfunction

    // Value-level sum: align to the larger operand, truncate, renormalize by
    // repeated halving/doubling. Returns {overflow, word}.
    function automatic logic [12:0] model_add(input logic [11:0] a, input logic [11:0] b);
        int ea, eb, ma, mb, e, m, sh, contrib;
        logic sa, sb, s;
        ea = int'(a[10:6]); eb = int'(b[10:6]);
        if (ea == 0) return {1'b0, norm(b)};
        if (eb == 0) return {1'b0, a};
        ma = 64 + int'(a[5:0]); mb = 64 + int'(b[5:0]);
        sa = a[11]; sb = b[11];
        if ((ea > eb) || (ea == eb && ma >= mb)) begin
            e = ea; s = sa; sh = ea - eb; m = ma;
            contrib = (sh >= 8) ? 0 : mb / (2 ** sh);
        end else begin
            e = eb; s = sb; sh = eb - ea; m = mb;
            contrib = (sh >= 8) ? 0 : ma / (2 ** sh);
        end
        m = (sa == sb) ? m + contrib : m - contrib;
        if (m == 0) return 13'd0;
        while (m >= 128) begin m = m / 2; e = e + 1; end
        while (m < 64)   begin m = m * 2; e = e - 1; end
        if (e < 1)  return 13'd0;
        if (e > 31) return {1'b1, s, 5'd31, 6'd63};
        return {1'b0, s, 5'(e), 6'(m)};
    endfunction

    task automatic model_edge(input logic v, input logic [11:0] d, input logic l,
                              input logic r, input logic rs);
        logic ok;
        logic [12:0] res;
        if (rs) begin
            m_active = 1'b0; m_pend = 1'b0; m_acc = 12'h000; m_cnt = 0; m_ovf = 1'b0;
            m_out = 12'h000; m_ocnt = 0; m_oovf = 1'b0;
            return;
        end
        ok = v && (!m_pend || r);
        if (m_pend && r) m_pend = 1'b0;
        if (ok) begin
            if (!m_active) begin
                m_acc = norm(d); m_cnt = 1; m_ovf = 1'b0;
            end else begin
                res   = model_add(m_acc, d);
                m_acc = res[11:0];
                m_ovf = m_ovf | res[12];
                m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
            end
            m_active = 1'b1;
            if (l) begin
                m_active = 1'b0; m_pend = 1'b1;
                m_out = m_acc; m_ocnt = m_cnt; m_oovf = m_ovf;
            end
        end
    endtask

    // One clock: drive, check ready_o, clock edge, update model, check outputs.
    task automatic cyc(input logic v, input logic [11:0] d, input logic l,
                       input logic r, input logic rs);
        bus.valid_i = v; bus.data_i = d; bus.last_i = l; bus.ready_i = r; rst = rs;
        #1;
        if (!rs) check("ready_o", 32'(bus.ready_o), 32'(!m_pend || r));
        @(posedge clk);
        model_edge(v, d, l, r, rs);
        #1;
        check("valid_o", 32'(bus.valid_o), 32'(m_pend));
        if (m_pend) begin
            check("data_o",  32'(bus.data_o),  32'(m_out));
            check("ovf_o",   32'(bus.ovf_o),   32'(m_oovf));
            check("count_o", 32'(bus.count_o), 32'(m_ocnt));
        end
    endtask

    task automatic idle();
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic v, l, r, rs;
        logic [11:0] d;

        bus.valid_i = 1'b0; bus.data_i = 12'h000; bus.last_i = 1'b0; bus.ready_i = 1'b1;

        // Reset, with a beat offered during reset that must be ignored.
        cyc(1'b1, 12'h3C0, 1'b1, 1'b1, 1'b1);
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
        check("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check("rst_data_o",  32'(bus.data_o),  32'h000);
        check("rst_ovf_o",   32'(bus.ovf_o),   32'd0);
        check("rst_count_o", 32'(bus.count_o), 32'd0);
        idle();

        // 1.0 + 0.5
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h380, 1'b1, 1'b1, 1'b0);
        check("half_data",  32'(bus.data_o),  32'h3E0);
        check("half_count", 32'(bus.count_o), 32'd2);
        check("half_ovf",   32'(bus.ovf_o),   32'd0);
        idle();

        // Exact cancellation, then shift of 8 dropped
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'hBC0, 1'b1, 1'b1, 1'b0);
        check("cancel_data", 32'(bus.data_o), 32'h000);
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h1C0, 1'b1, 1'b1, 1'b0);
        check("shift8_data", 32'(bus.data_o), 32'h3C0);
        idle();

        // Saturation, then ovf clears for the next group
        cyc(1'b1, 12'h7FF, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h7FF, 1'b1, 1'b1, 1'b0);
        check("sat_data", 32'(bus.data_o), 32'h7FF);
        check("sat_ovf",  32'(bus.ovf_o),  32'd1);
        cyc(1'b1, 12'h3C0, 1'b1, 1'b1, 1'b0);
        check("after_sat_data",  32'(bus.data_o),  32'h3C0);
        check("after_sat_ovf",   32'(bus.ovf_o),   32'd0);
        check("after_sat_count", 32'(bus.count_o), 32'd1);

        // Backpressure: result held for 3 cycles, then swap in one cycle
        held = bus.data_o;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 12'h380, 1'b1, 1'b0, 1'b0);
            check("bp_ready_o", 32'(bus.ready_o), 32'd0);
            check("bp_hold",    32'(bus.data_o),  32'(held));
        end
        cyc(1'b1, 12'h380, 1'b1, 1'b1, 1'b0);
        check("swap_valid", 32'(bus.valid_o), 32'd1);
        check("swap_data",  32'(bus.data_o),  32'h380);
        check("swap_count", 32'(bus.count_o), 32'd1);

        // 300 zero beats, last on the final one: count saturates
        for (int i = 0; i < 300; i++)
            cyc(1'b1, 12'h000, (i == 299), 1'b1, 1'b0);
        check("long_count", 32'(bus.count_o), 32'd255);
        check("long_data",  32'(bus.data_o),  32'h000);
        idle();

        // Reset mid-group discards it
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 12'h000, 1'b0, 1'b1, 1'b1);
        check("midrst_valid", 32'(bus.valid_o), 32'd0);
        cyc(1'b1, 12'h3C0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 12'h3C0, 1'b1, 1'b1, 1'b0);
        check("midrst_data",  32'(bus.data_o),  32'h400);
        check("midrst_count", 32'(bus.count_o), 32'd2);
        idle();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            l  = ($urandom_range(0, 3) == 0);
            r  = ($urandom_range(0, 9) < 7);
            rs = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 3))
                0:       d = {~m_acc[11], m_acc[10:0]};
                1:       d = {1'($urandom), 5'($urandom_range(28, 31)), 6'($urandom)};
                default: d = 12'($urandom);
            endcase
            cyc(v, d, l, r, rs);
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/float_accum_12.md
FLOAT_ACCUM_12 -- requirements
Module: float_accum_12

Interface
- REQ-001: clk_i  input  1  single clock; all state updates on rising edge.
- REQ-002: rst_i  input  1  synchronous, active-high reset.
- REQ-003: data_i  input  12  product word from the upstream multiplier stage.
- REQ-004: valid_i  input  1  data_i/last_i valid this cycle.
- REQ-005: last_i  input  1  final beat of current accumulation group.
- REQ-006: ready_o  output  1  block accepts a beat this cycle.
- REQ-007: data_o  output  12  accumulated group sum.
- REQ-008: valid_o  output  1  data_o/ovf_o/count_o hold a finished result.
- REQ-009: ready_i  input  1  downstream consumes the result this cycle.
- REQ-010: ovf_o  output  1  an overflow saturation occurred somewhere in this group.
- REQ-011: count_o  output  8  number of beats in the reported group, saturating at 255.

Function
- REQ-012: Word format SHALL be [11] sign, [10:6] exponent (bias 15), [5:0] fraction with hidden 1.
- REQ-013: Any input with exponent 0 SHALL be treated as zero, including 12'h000 and 12'h800.
- REQ-014: Zero results SHALL always be emitted as 12'h000.
- REQ-015: A beat SHALL be accepted when valid_i && ready_o.
- REQ-016: ready_o SHALL equal !valid_o || ready_i, so a result and a new beat can be exchanged in the same cycle.
- REQ-017: States SHALL be IDLE (no partial sum), ACC (partial sum held) and DONE (valid_o=1).
- REQ-018: IDLE + accepted beat: acc <= normalized data_i and count <= 1; go to ACC, or to DONE if last_i.
- REQ-019: ACC + accepted beat: acc <= add(acc, data_i) and count increments, saturating at 255; go to DONE if last_i.
- REQ-020: The partial sum, count and ovf SHALL be held when no beat is accepted.
- REQ-021: Entering DONE SHALL load data_o, ovf_o and count_o and assert valid_o.
- REQ-022: Latency SHALL be exactly one cycle from acceptance of the last beat to valid_o.
- REQ-023: Full throughput SHALL be one beat per cycle with no bubbles.
- REQ-024: DONE with ready_i=1 and no accepted beat: clear valid_o and go to IDLE.
- REQ-025: DONE with ready_i=1 and an accepted beat: that beat SHALL start a new group per REQ-018.
- REQ-026: DONE with ready_i=0: all outputs SHALL be held stable and ready_o=0.
- REQ-027: Add, alignment: the operand with the smaller exponent SHALL be right-shifted by the exponent difference, truncating bits.
- REQ-028: Add, large shift: a shift of 8 or more SHALL contribute nothing.
- REQ-029: Add, magnitude: 7-bit mantissas {1, frac} SHALL be added (equal signs) or smaller subtracted from larger (different signs).
- REQ-030: Add, sign: the result sign SHALL be the sign of the larger magnitude, compared by exponent then fraction.
- REQ-031: Add, normalization: a carry-out SHALL shift right once and increment the exponent; leading zeros SHALL shift left and decrement the exponent.
- REQ-032: Add, rounding: the fraction SHALL be truncated (round toward zero); there is no rounding increment.
- REQ-033: Exact cancellation SHALL yield 12'h000.
- REQ-034: A result exponent below 1 SHALL flush to 12'h000, with no flag.
- REQ-035: A result exponent above 31 SHALL saturate to {sign, 5'd31, 6'd63} and set the group ovf bit.
- REQ-036: Once saturated, the partial sum SHALL continue to accumulate normally from the saturated value.
- REQ-037: ovf SHALL clear at the start of each new group.

Reset
- REQ-038: rst_i=1 at a clock edge SHALL force state IDLE, acc=0, count=0, ovf=0.
- REQ-039: rst_i=1 SHALL force data_o=12'h000, valid_o=0, ovf_o=0 and count_o=0.
- REQ-040: ready_o SHALL be 1 in the first cycle after reset deasserts.
- REQ-041: Reset mid-group or in DONE SHALL discard the partial or pending result; no output is produced for it.
- REQ-042: Beats presented while rst_i=1 SHALL be ignored.

Verification
- REQ-043: 12'h3C0 (1.0), 12'h380 (0.5, last) -> next cycle valid_o=1, data_o=12'h3E0, count_o=2, ovf_o=0.
- REQ-044: 12'h3C0, 12'hBC0 (last) -> data_o=12'h000; 12'h3C0, 12'h1C0 (last) -> data_o=12'h3C0 (shift 8 dropped).
- REQ-045: 12'h7FF, 12'h7FF (last) -> data_o=12'h7FF, ovf_o=1; the next group {12'h3C0 last} -> data_o=12'h3C0, ovf_o=0, count_o=1.
- REQ-046: Result pending with ready_i=0 for 3 cycles -> ready_o=0 and data_o/valid_o stable; then ready_i=1 with valid_i=1 -> result consumed and new beat accepted in the same cycle.
- REQ-047: 300 beats of 12'h000 then last -> count_o=255, data_o=12'h000.
- REQ-048: rst_i=1 for one cycle after 2 of 4 beats -> no valid_o for that group; the following 2-beat group 12'h3C0, 12'h3C0 -> data_o=12'h400.
